// File: rtl/reg_cmd_ctrl_if.sv
// ---------------------------------------------------------------------------
// reg_cmd_ctrl_if
//
// Purpose:
//   Bundles every non-clock signal of the byte command controller: the serial
//   receive byte stream, the serial transmit handshake, the register-file
//   strobes/address/data and the status flags.
//
// Signals:
//   RX_Data   [7:0]            received byte
//   RX_Valid                   one-cycle pulse qualifying RX_Data
//   TX_Data   [7:0]            byte to transmit
//   TX_Valid                   TX_Data valid, held until accepted
//   TX_Ready                   transmitter accepts when TX_Valid && TX_Ready
//   WrEn                       register-file write strobe
//   RdEn                       register-file read strobe
//   Address   [ADDR_WIDTH-1:0] register-file address
//   WrData    [15:0]           register-file write data
//   RdData    [15:0]           register-file read data, one cycle after RdEn
//   Busy                       controller not idle
//   Frame_Err                  one-cycle pulse on a dropped byte or frame
//
// Modports:
//   master - the controller (drives TX, strobes, address, data, status)
//   slave  - the surrounding serial path and register file
// ---------------------------------------------------------------------------
interface reg_cmd_ctrl_if #(
    parameter int ADDR_WIDTH = 3
);
    logic [7:0]            RX_Data;
    logic                  RX_Valid;
    logic [7:0]            TX_Data;
    logic                  TX_Valid;
    logic                  TX_Ready;
    logic                  WrEn;
    logic                  RdEn;
    logic [ADDR_WIDTH-1:0] Address;
    logic [15:0]           WrData;
    logic [15:0]           RdData;
    logic                  Busy;
    logic                  Frame_Err;

    // Controller side
    modport master (
        input  RX_Data,
        input  RX_Valid,
        input  TX_Ready,
        input  RdData,
        output TX_Data,
        output TX_Valid,
        output WrEn,
        output RdEn,
        output Address,
        output WrData,
        output Busy,
        output Frame_Err
    );

    // Serial path and register-file side
    modport slave (
        output RX_Data,
        output RX_Valid,
        output TX_Ready,
        output RdData,
        input  TX_Data,
        input  TX_Valid,
        input  WrEn,
        input  RdEn,
        input  Address,
        input  WrData,
        input  Busy,
        input  Frame_Err
    );
endinterface

// File: rtl/reg_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// reg_cmd_ctrl
//
// Purpose:
//   Byte-oriented command controller in front of a 16-bit, 8-entry register
//   file. Parses command frames from the serial receive path and turns them
//   into single-cycle register-file write or read strobes. Read data is
//   returned to the serial transmit path as two bytes, high byte first.
//
//   Write frame : WR_CMD, addr, data_hi, data_lo
//   Read frame  : RD_CMD, addr        -> response RdData[15:8], RdData[7:0]
//
// Parameters:
//   ADDR_WIDTH  register-file address width; upper address-byte bits must be 0
//   WR_CMD      opcode byte starting a write frame
//   RD_CMD      opcode byte starting a read frame
//
// Ports:
//   CLK  system clock, rising edge
//   RST  asynchronous, active-high reset
//   bus  reg_cmd_ctrl_if.master (RX bytes, TX handshake, register-file
//        strobes/address/data, Busy, Frame_Err)
// ---------------------------------------------------------------------------
module reg_cmd_ctrl #(
    parameter int         ADDR_WIDTH = 3,
    parameter logic [7:0] WR_CMD     = 8'hAA,
    parameter logic [7:0] RD_CMD     = 8'hBB
) (
    input  logic           CLK,
    input  logic           RST,
    reg_cmd_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DHI,
        WR_DLO,
        WR_EXEC,
        RD_ADDR,
        RD_EXEC,
        RD_WAIT,
        TX_HI,
        TX_LO
    } state_t;

    state_t state_q;
    state_t state_d;

    // Datapath registers
    logic [ADDR_WIDTH-1:0] address_q;
    logic [15:0]           wrData_q;
    logic [15:0]           held_q;
    logic                  busy_q;
    logic                  frameErr_q;

    // Decoded controls from the output process
    logic       frameErr_d;
    logic       loadAddr;
    logic       loadHi;
    logic       loadLo;
    logic       loadHeld;
    logic       wrEn;
    logic       rdEn;
    logic       txValid;
    logic [7:0] txData;

    // An address byte is legal only when the bits above the register-file
    // address width are all zero.
    logic addrOk;
    assign addrOk = (bus.RX_Data[7:ADDR_WIDTH] == '0);

    // State register. Reset abandons any frame in progress immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: byte-driven frame parsing, fixed single-cycle execute
    // states, and the two-byte transmit handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.RX_Valid) begin
                    if (bus.RX_Data == WR_CMD) begin
                        state_d = WR_ADDR;
                    end else if (bus.RX_Data == RD_CMD) begin
                        state_d = RD_ADDR;
                    end
                end
            end
            WR_ADDR: begin
                if (bus.RX_Valid) begin
                    state_d = addrOk ? WR_DHI : IDLE;
                end
            end
            WR_DHI: begin
                if (bus.RX_Valid) begin
                    state_d = WR_DLO;
                end
            end
            WR_DLO: begin
                if (bus.RX_Valid) begin
                    state_d = WR_EXEC;
                end
            end
            WR_EXEC: state_d = IDLE;
            RD_ADDR: begin
                if (bus.RX_Valid) begin
                    state_d = addrOk ? RD_EXEC : IDLE;
                end
            end
            RD_EXEC: state_d = RD_WAIT;
            RD_WAIT: state_d = TX_HI;
            TX_HI: begin
                if (bus.TX_Ready) begin
                    state_d = TX_LO;
                end
            end
            TX_LO: begin
                if (bus.TX_Ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/control decode. Strobes and TX signals come straight from the
    // state register so they are stable for the whole cycle. Bytes arriving
    // in a state that cannot consume them are flagged as errors.
    always_comb begin
        frameErr_d = 1'b0;
        loadAddr   = 1'b0;
        loadHi     = 1'b0;
        loadLo     = 1'b0;
        loadHeld   = 1'b0;
        wrEn       = 1'b0;
        rdEn       = 1'b0;
        txValid    = 1'b0;
        txData     = 8'h00;
        case (state_q)
            IDLE: begin
                frameErr_d = bus.RX_Valid &&
                             (bus.RX_Data != WR_CMD) && (bus.RX_Data != RD_CMD);
            end
            WR_ADDR, RD_ADDR: begin
                loadAddr   = bus.RX_Valid && addrOk;
                frameErr_d = bus.RX_Valid && !addrOk;
            end
            WR_DHI: loadHi = bus.RX_Valid;
            WR_DLO: loadLo = bus.RX_Valid;
            WR_EXEC: begin
                wrEn       = 1'b1;
                frameErr_d = bus.RX_Valid;
            end
            RD_EXEC: begin
                rdEn       = 1'b1;
                frameErr_d = bus.RX_Valid;
            end
            RD_WAIT: begin
                loadHeld   = 1'b1;
                frameErr_d = bus.RX_Valid;
            end
            TX_HI: begin
                txValid    = 1'b1;
                txData     = held_q[15:8];
                frameErr_d = bus.RX_Valid;
            end
            TX_LO: begin
                txValid    = 1'b1;
                txData     = held_q[7:0];
                frameErr_d = bus.RX_Valid;
            end
            default: ;
        endcase
    end

    // Datapath and status registers. Address and write data hold their value
    // until the next frame overwrites them. Busy tracks the upcoming state so
    // it lines up with the state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            address_q  <= '0;
            wrData_q   <= 16'h0000;
            held_q     <= 16'h0000;
            busy_q     <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            if (loadAddr) begin
                address_q <= bus.RX_Data[ADDR_WIDTH-1:0];
            end
            if (loadHi) begin
                wrData_q[15:8] <= bus.RX_Data;
            end
            if (loadLo) begin
                wrData_q[7:0] <= bus.RX_Data;
            end
            if (loadHeld) begin
                held_q <= bus.RdData;
            end
            busy_q     <= (state_d != IDLE);
            frameErr_q <= frameErr_d;
        end
    end

    assign bus.WrEn      = wrEn;
    assign bus.RdEn      = rdEn;
    assign bus.TX_Valid  = txValid;
    assign bus.TX_Data   = txData;
    assign bus.Address   = address_q;
    assign bus.WrData    = wrData_q;
    assign bus.Busy      = busy_q;
    assign bus.Frame_Err = frameErr_q;

endmodule

// File: doc/reg_cmd_ctrl.md
# reg_cmd_ctrl

Byte-oriented command controller sitting directly upstream of the 16-bit, 8-entry register file. It parses command frames arriving as bytes from the serial receive path and converts them into single-cycle register-file write or read strobes. For reads it returns the 16-bit read data as two bytes to the serial transmit path. It runs in the register-file clock domain.

## Interface
- ADDR_WIDTH, 3, register-file address width; address byte bits [7:ADDR_WIDTH] must be zero.
- WR_CMD, 8'hAA, opcode byte that starts a write frame.
- RD_CMD, 8'hBB, opcode byte that starts a read frame.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- RX_Data  in  8  received byte.
- RX_Valid  in  1  one-cycle pulse qualifying RX_Data.
- TX_Data  out  8  byte to transmit.
- TX_Valid  out  1  TX_Data valid; held until accepted.
- TX_Ready  in  1  transmitter accepts the byte when TX_Valid && TX_Ready.
- WrEn  out  1  register-file write strobe.
- RdEn  out  1  register-file read strobe.
- Address  out  ADDR_WIDTH  register-file address.
- WrData  out  16  register-file write data.
- RdData  in  16  register-file read data, valid one cycle after RdEn.
- Busy  out  1  high whenever the state is not IDLE.
- Frame_Err  out  1  one-cycle pulse on a dropped byte or frame.

## Operation
- Write frame: WR_CMD, addr, data_hi, data_lo. Read frame: RD_CMD, addr. Response: RdData[15:8], then RdData[7:0].
- States: IDLE, WR_ADDR, WR_DHI, WR_DLO, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_HI, TX_LO.
- IDLE: RX byte == WR_CMD -> WR_ADDR. RX byte == RD_CMD -> RD_ADDR. Any other byte is dropped, Frame_Err pulses, state stays IDLE.
- WR_ADDR / RD_ADDR on RX_Valid:
  - If addr[7:ADDR_WIDTH] != 0: Frame_Err pulses, return to IDLE, no strobe.
  - Otherwise latch Address, then go to WR_DHI or RD_EXEC respectively.
- Write path:
  - WR_DHI latches WrData[15:8] and goes to WR_DLO.
  - WR_DLO latches WrData[7:0] and goes to WR_EXEC.
  - WR_EXEC: WrEn = 1 for exactly one cycle, then IDLE.
- Read path:
  - RD_EXEC: RdEn = 1 for exactly one cycle, then RD_WAIT.
  - RD_WAIT: capture RdData into an internal 16-bit holding register, go to TX_HI.
- Transmit:
  - TX_HI: TX_Data = held[15:8], TX_Valid = 1. On TX_Ready go to TX_LO.
  - TX_LO: TX_Data = held[7:0], TX_Valid = 1. On TX_Ready go to IDLE.
- RX_Valid while in WR_EXEC, RD_EXEC, RD_WAIT, TX_HI or TX_LO: byte dropped, Frame_Err pulses, state unaffected.
- No inter-byte timeout; a partial frame waits indefinitely.
- WrEn and RdEn are never high in the same cycle.

## Timing
- Reset values: all outputs 0 (WrEn, RdEn, TX_Valid, Busy, Frame_Err, Address, WrData, TX_Data). State = IDLE, holding register = 0.
- Reset asserted mid-frame or mid-transmit: the frame is abandoned immediately, with no strobe and no further TX byte.
- WrEn is registered: it asserts on the first edge after the edge that accepted data_lo. Address and WrData are stable during WrEn and held afterwards until overwritten.
- Read latency from the edge accepting the addr byte:
  - RdEn high in cycle +1.
  - RdData captured in cycle +2.
  - TX_Valid high from cycle +3.
- TX_Valid and TX_Data do not change until accepted. Back-to-back acceptance is allowed: TX_Ready high continuously gives the high byte in one cycle and the low byte in the next.
- The low byte's acceptance edge returns the state to IDLE. A command byte in the next cycle is accepted.
- Busy is a registered decode of the state (state != IDLE).

## Test plan
- Reset: assert RST mid-cycle -> all outputs 0 asynchronously, Busy = 0.
- Write: bytes AA, 03, 00, 23 -> one-cycle WrEn with Address = 3, WrData = 16'd35. Then AA, 01, 00, 66 -> WrEn with Address = 1, WrData = 16'd102.
- Read with RdData model returning 16'h008F at address 7: bytes BB, 07 -> RdEn with Address = 7, then TX bytes 00 then 8F. Stall TX_Ready low for 5 cycles -> TX_Data and TX_Valid held stable throughout.
- Errors:
  - Byte 55 in IDLE -> Frame_Err pulse, no strobe.
  - Bytes AA, 09 -> Frame_Err, back to IDLE, no WrEn.
  - RX byte during TX_HI -> Frame_Err, response still 2 correct bytes.
- Reset mid-frame: AA, 02, 00, then RST pulse, then 1B -> no WrEn, 1B dropped with Frame_Err. A following full frame AA, 02, 00, 1B writes 16'd27 to address 2.
